// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: init-sequencer states, command encodings
// ({cs_n, ras_n, cas_n, we_n}) and the shortened power-up wait for fast simulation.
package sdram_pkg;

  typedef enum logic [3:0] {
    ST_WAIT_LOCK,
    ST_PWRUP_WAIT,
    ST_PRECHARGE,
    ST_WAIT_RP,
    ST_REFRESH,
    ST_WAIT_RFC,
    ST_LOAD_MODE,
    ST_WAIT_MRD,
    ST_DONE
  } pwrup_state_e;

  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

  localparam logic [15:0] FAST_SIM_PWRUP_CYC = 16'd16;

  // A wait of n cycles ends when the counter, started at 0, hits n-1.
  function automatic logic [15:0] last_cyc(input int n);
    return 16'(n - 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level signal.
// Clears to 0 on asynchronous active-low reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/sdram_pwrup_seq.sv
// SDRAM power-up sequencer: lock wait, stabilisation, PRECHARGE ALL, AUTO REFRESH
// burst, LOAD MODE. SDRAM_PWRUP_FAST_SIM_EN shortens the power-up wait to 16 cycles.
module sdram_pwrup_seq
  import sdram_pkg::*;
#(
  parameter int          CLK_FREQ_MHZ  = 133,
  parameter int          PWRUP_US      = 200,
  parameter int          T_RP_CYC      = 3,
  parameter int          T_RFC_CYC     = 9,
  parameter int          T_MRD_CYC     = 2,
  parameter int          REFRESH_COUNT = 8,
  parameter logic [12:0] MODE_REG      = 13'h0030
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_pll_locked,
  output logic        o_cke,
  output logic [3:0]  o_cmd,
  output logic [12:0] o_addr,
  output logic [1:0]  o_ba,
  output logic        o_init_done
);

`ifdef SDRAM_PWRUP_FAST_SIM_EN
  localparam bit FAST_SIM = 1'b1;
`else
  localparam bit FAST_SIM = 1'b0;
`endif

  localparam logic [15:0] PWRUP_LAST = FAST_SIM ?
    (FAST_SIM_PWRUP_CYC - 16'd1) :
    last_cyc(CLK_FREQ_MHZ * PWRUP_US);
  localparam logic [15:0] RP_LAST  = last_cyc(T_RP_CYC);
  localparam logic [15:0] RFC_LAST = last_cyc(T_RFC_CYC);
  localparam logic [15:0] MRD_LAST = last_cyc(T_MRD_CYC);
  localparam logic [3:0]  REF_N    = 4'(REFRESH_COUNT);

  logic         w_locked;
  pwrup_state_e r_state;
  pwrup_state_e w_next;
  logic [15:0]  r_wait_cnt;
  logic [15:0]  w_wait_nxt;
  logic [3:0]   r_ref_cnt;
  logic [3:0]   w_ref_nxt;

  logic         r_cke;
  logic [3:0]   r_cmd;
  logic [12:0]  r_addr;
  logic [1:0]   r_ba;
  logic         r_done;

  logic         w_cke;
  logic [3:0]   w_cmd;
  logic [12:0]  w_addr;
  logic [1:0]   w_ba;
  logic         w_done;

  sync_2ff u_lock_sync (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_d    (i_pll_locked),
    .o_q    (w_locked)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= ST_WAIT_LOCK;
      r_wait_cnt <= 16'd0;
      r_ref_cnt  <= 4'd0;
      r_cke      <= 1'b0;
      r_cmd      <= CMD_NOP;
      r_addr     <= 13'd0;
      r_ba       <= 2'd0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_nxt;
      r_ref_cnt  <= w_ref_nxt;
      r_cke      <= w_cke;
      r_cmd      <= w_cmd;
      r_addr     <= w_addr;
      r_ba       <= w_ba;
      r_done     <= w_done;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_wait_nxt = r_wait_cnt;
    w_ref_nxt  = r_ref_cnt;
    unique case (r_state)
      ST_WAIT_LOCK: begin
        w_wait_nxt = 16'd0;
        if (w_locked) w_next = ST_PWRUP_WAIT;
      end
      ST_PWRUP_WAIT: begin
        if (r_wait_cnt == PWRUP_LAST) begin
          w_next     = ST_PRECHARGE;
          w_wait_nxt = 16'd0;
        end else begin
          w_wait_nxt = r_wait_cnt + 16'd1;
        end
      end
      ST_PRECHARGE: begin
        w_next = ST_WAIT_RP;
      end
      ST_WAIT_RP: begin
        if (r_wait_cnt == RP_LAST) begin
          w_next     = ST_REFRESH;
          w_wait_nxt = 16'd0;
        end else begin
          w_wait_nxt = r_wait_cnt + 16'd1;
        end
      end
      ST_REFRESH: begin
        w_next = ST_WAIT_RFC;
        if (r_ref_cnt != 4'hF) w_ref_nxt = r_ref_cnt + 4'd1;
      end
      ST_WAIT_RFC: begin
        if (r_wait_cnt == RFC_LAST) begin
          w_wait_nxt = 16'd0;
          if (r_ref_cnt < REF_N) w_next = ST_REFRESH;
          else w_next = ST_LOAD_MODE;
        end else begin
          w_wait_nxt = r_wait_cnt + 16'd1;
        end
      end
      ST_LOAD_MODE: begin
        w_next = ST_WAIT_MRD;
      end
      ST_WAIT_MRD: begin
        if (r_wait_cnt == MRD_LAST) begin
          w_next     = ST_DONE;
          w_wait_nxt = 16'd0;
        end else begin
          w_wait_nxt = r_wait_cnt + 16'd1;
        end
      end
      ST_DONE: begin
        w_next = ST_DONE;
      end
      default: begin
        w_next     = ST_WAIT_LOCK;
        w_wait_nxt = 16'd0;
        w_ref_nxt  = 4'd0;
      end
    endcase
    // Losing lock anywhere abandons the sequence and starts over.
    if (!w_locked) begin
      w_next     = ST_WAIT_LOCK;
      w_wait_nxt = 16'd0;
      w_ref_nxt  = 4'd0;
    end
  end

  // Outputs decode the next state so the registered pins line up with r_state.
  always_comb begin
    w_cke  = (w_next != ST_WAIT_LOCK);
    w_cmd  = CMD_NOP;
    w_addr = 13'd0;
    w_ba   = 2'd0;
    w_done = (w_next == ST_DONE);
    unique case (w_next)
      ST_PRECHARGE: begin
        w_cmd  = CMD_PRECHARGE;
        w_addr = 13'h0400;
      end
      ST_REFRESH: begin
        w_cmd = CMD_REFRESH;
      end
      ST_LOAD_MODE: begin
        w_cmd  = CMD_LOAD_MODE;
        w_addr = MODE_REG;
      end
      default: begin
        w_cmd = CMD_NOP;
      end
    endcase
  end

  assign o_cke       = r_cke;
  assign o_cmd       = r_cmd;
  assign o_addr      = r_addr;
  assign o_ba        = r_ba;
  assign o_init_done = r_done;

endmodule

// File: tb/tb_sdram_pwrup_seq.sv
// Bench for sdram_pwrup_seq: checkpoint table for the full sequence plus
// lock-loss, async reset, lock glitch and full-length power-up wait cases.
module tb_sdram_pwrup_seq;
  import sdram_pkg::*;

  typedef struct packed {
    logic        cke;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic        done;
  } out_t;

  typedef struct {
    int   cyc;
    logic lock;
    out_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lock = 1'b0;
  logic        lock_d = 1'b0;
  logic        cke, cke_d;
  logic [3:0]  cmd, cmd_d;
  logic [12:0] addr, addr_d;
  logic [1:0]  ba, ba_d;
  logic        done, done_d;

  always #5 clk = ~clk;

  sdram_pwrup_seq #(
    .CLK_FREQ_MHZ (1),
    .PWRUP_US     (16)
  ) u_dut (
    .i_clk        (clk),
    .i_rstn       (rst_n),
    .i_pll_locked (lock),
    .o_cke        (cke),
    .o_cmd        (cmd),
    .o_addr       (addr),
    .o_ba         (ba),
    .o_init_done  (done)
  );

  sdram_pwrup_seq u_def (
    .i_clk        (clk),
    .i_rstn       (rst_n),
    .i_pll_locked (lock_d),
    .o_cke        (cke_d),
    .o_cmd        (cmd_d),
    .o_addr       (addr_d),
    .o_ba         (ba_d),
    .o_init_done  (done_d)
  );

`ifdef SDRAM_PWRUP_FAST_SIM_EN
  localparam int DEF_PWRUP = 16;
`else
  localparam int DEF_PWRUP = 133 * 200;
`endif

  int n_vec = 0;
  int n_bad = 0;

  // Bus monitor on the main instance.
  int          tcyc = 0;
  int          n_pre = 0;
  int          n_ref = 0;
  int          n_lmr = 0;
  int          last_ref = 0;
  int          spc_bad = 0;
  int          viol = 0;
  logic [12:0] lmr_addr = 13'd0;
  logic        mon_clr = 1'b0;
  logic        mon_bad;

  assign mon_bad =
    ((cmd == CMD_NOP || cmd == CMD_REFRESH) && (addr != 13'd0 || ba != 2'd0)) ||
    (cmd == CMD_PRECHARGE && !addr[10]) ||
    (cmd == CMD_LOAD_MODE && ba != 2'd0) ||
    !(cmd inside {CMD_NOP, CMD_PRECHARGE, CMD_REFRESH, CMD_LOAD_MODE}) ||
    (!cke && cmd != CMD_NOP) ||
    (done && cmd != CMD_NOP);

  always @(negedge clk) begin
    tcyc <= tcyc + 1;
    if (mon_clr) begin
      n_pre    <= 0;
      n_ref    <= 0;
      n_lmr    <= 0;
      last_ref <= 0;
      spc_bad  <= 0;
      viol     <= 0;
      lmr_addr <= 13'd0;
    end else begin
      if (mon_bad) viol <= viol + 1;
      if (cmd == CMD_PRECHARGE) n_pre <= n_pre + 1;
      if (cmd == CMD_LOAD_MODE) begin
        n_lmr    <= n_lmr + 1;
        lmr_addr <= addr;
      end
      if (cmd == CMD_REFRESH) begin
        if (n_ref != 0 && tcyc - last_ref != 10) spc_bad <= spc_bad + 1;
        last_ref <= tcyc;
        n_ref    <= n_ref + 1;
      end
    end
  end

  function automatic out_t mk_out(input logic c, input logic [3:0] k,
                                  input logic [12:0] a, input logic d);
    out_t o;
    o.cke  = c;
    o.cmd  = k;
    o.addr = a;
    o.ba   = 2'd0;
    o.done = d;
    return o;
  endfunction

  function automatic vec_t mk_vec(input int cy, input logic [3:0] k,
                                  input logic [12:0] a, input logic d);
    vec_t v;
    v.cyc  = cy;
    v.lock = 1'b1;
    v.exp  = mk_out(1'b1, k, a, d);
    return v;
  endfunction

  function automatic out_t cur();
    out_t o;
    o.cke  = cke;
    o.cmd  = cmd;
    o.addr = addr;
    o.ba   = ba;
    o.done = done;
    return o;
  endfunction

  function automatic out_t cur_d();
    out_t o;
    o.cke  = cke_d;
    o.cmd  = cmd_d;
    o.addr = addr_d;
    o.ba   = ba_d;
    o.done = done_d;
    return o;
  endfunction

  task automatic chk_out(input string nm, input out_t act, input out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got cke=%b cmd=%b addr=%h ba=%h done=%b, want cke=%b cmd=%b addr=%h ba=%h done=%b",
               nm, act.cke, act.cmd, act.addr, act.ba, act.done,
               exp.cke, exp.cmd, exp.addr, exp.ba, exp.done);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_cke(input logic val, input int lim, output int n);
    n = 0;
    while (cke !== val && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_done(input int lim, output int n);
    n = 0;
    while (done !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic clr_mon();
    @(posedge clk);
    mon_clr = 1'b1;
    @(posedge clk);
    mon_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_seq(input string nm);
    chk_int({nm, "_n_pre"}, n_pre, 1);
    chk_int({nm, "_n_ref"}, n_ref, 8);
    chk_int({nm, "_n_lmr"}, n_lmr, 1);
    chk_int({nm, "_spacing"}, spc_bad, 0);
    chk_int({nm, "_bus_rules"}, viol, 0);
  endtask

  out_t RST;
  vec_t tbl[$];
  int   n;
  int   rel;

  initial begin
    RST = mk_out(1'b0, CMD_NOP, 13'd0, 1'b0);
    tbl.push_back(mk_vec(0,   CMD_NOP,       13'd0,    1'b0));
    tbl.push_back(mk_vec(15,  CMD_NOP,       13'd0,    1'b0));
    tbl.push_back(mk_vec(16,  CMD_PRECHARGE, 13'h0400, 1'b0));
    tbl.push_back(mk_vec(17,  CMD_NOP,       13'd0,    1'b0));
    tbl.push_back(mk_vec(19,  CMD_NOP,       13'd0,    1'b0));
    tbl.push_back(mk_vec(20,  CMD_REFRESH,   13'd0,    1'b0));
    tbl.push_back(mk_vec(21,  CMD_NOP,       13'd0,    1'b0));
    tbl.push_back(mk_vec(29,  CMD_NOP,       13'd0,    1'b0));
    tbl.push_back(mk_vec(30,  CMD_REFRESH,   13'd0,    1'b0));
    tbl.push_back(mk_vec(50,  CMD_REFRESH,   13'd0,    1'b0));
    tbl.push_back(mk_vec(90,  CMD_REFRESH,   13'd0,    1'b0));
    tbl.push_back(mk_vec(91,  CMD_NOP,       13'd0,    1'b0));
    tbl.push_back(mk_vec(99,  CMD_NOP,       13'd0,    1'b0));
    tbl.push_back(mk_vec(100, CMD_LOAD_MODE, 13'h0030, 1'b0));
    tbl.push_back(mk_vec(101, CMD_NOP,       13'd0,    1'b0));
    tbl.push_back(mk_vec(102, CMD_NOP,       13'd0,    1'b0));
    tbl.push_back(mk_vec(103, CMD_NOP,       13'd0,    1'b1));
    tbl.push_back(mk_vec(110, CMD_NOP,       13'd0,    1'b1));

    repeat (3) @(negedge clk);
    chk_out("reset_main", cur(), RST);
    chk_out("reset_def", cur_d(), RST);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_out("idle_no_lock", cur(), RST);

    // Glitch inside the low clock phase: never sampled.
    #1 lock = 1'b1;
    #2 lock = 1'b0;
    repeat (6) @(negedge clk);
    chk_out("glitch_no_edge", cur(), RST);

    // Glitch straddling a rising edge: at most a clean start, then back off.
    #4 lock = 1'b1;
    #2 lock = 1'b0;
    repeat (8) @(negedge clk);
    chk_out("glitch_edge_idle", cur(), RST);
    chk_int("glitch_no_cmd", n_pre + n_ref + n_lmr + viol, 0);

    // Full sequence against the checkpoint table.
    clr_mon();
    lock = 1'b1;
    wait_cke(1'b1, 10, n);
    chk_int("lock_to_cke", n, 3);
    rel = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      while (rel < tbl[i].cyc) begin
        @(negedge clk);
        rel++;
      end
      lock = tbl[i].lock;
      chk_out($sformatf("vec%0d_cyc%0d", i, tbl[i].cyc), cur(), tbl[i].exp);
    end
    chk_seq("seq1");
    chk_int("seq1_mode", int'(lmr_addr), 'h30);

    // Lock loss from DONE.
    lock = 1'b0;
    wait_cke(1'b0, 10, n);
    chk_int("loss_done_lat", n, 3);
    chk_out("loss_done_out", cur(), RST);

    // Lock loss during the 4th tRFC wait, then relock.
    clr_mon();
    lock = 1'b1;
    wait_cke(1'b1, 10, n);
    chk_int("relock_to_cke", n, 3);
    repeat (52) @(negedge clk);
    chk_out("in_rfc4", cur(), mk_out(1'b1, CMD_NOP, 13'd0, 1'b0));
    chk_int("refs_before_drop", n_ref, 4);
    lock = 1'b0;
    wait_cke(1'b0, 10, n);
    chk_int("drop_rfc_lat", n, 3);
    chk_out("drop_rfc_out", cur(), RST);
    clr_mon();
    lock = 1'b1;
    wait_cke(1'b1, 10, n);
    chk_int("relock2_to_cke", n, 3);
    wait_done(300, n);
    chk_int("relock2_done_at", n, 103);
    chk_seq("seq2");

    // Async reset pulse during the power-up wait.
    lock = 1'b0;
    wait_cke(1'b0, 10, n);
    clr_mon();
    lock = 1'b1;
    wait_cke(1'b1, 10, n);
    chk_int("pre_rst_to_cke", n, 3);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_out("async_reset", cur(), RST);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_cke(1'b1, 10, n);
    chk_int("post_rst_to_cke", n, 3);
    wait_done(300, n);
    chk_int("post_rst_done_at", n, 103);
    chk_seq("seq3");

    // Default-parameter instance: full-length power-up wait.
    lock_d = 1'b1;
    n = 0;
    while (cke_d !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk_int("def_lock_to_cke", n, 3);
    n = 0;
    while (cmd_d == CMD_NOP && cke_d && !done_d && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk_int("def_pwrup_len", n, DEF_PWRUP);
    chk_out("def_precharge", cur_d(), mk_out(1'b1, CMD_PRECHARGE, 13'h0400, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_pwrup_seq.md
SDRAM_PWRUP_SEQ -- requirements
Module: sdram_pwrup_seq

Interface
REQ-001 Parameter CLK_FREQ_MHZ, default 133, is the i_clk frequency in MHz and scales the power-up wait.
REQ-002 Parameter PWRUP_US, default 200, is the post-lock power-up stabilisation time in microseconds.
REQ-003 Parameter T_RP_CYC, default 3, is the number of NOP cycles after PRECHARGE ALL.
REQ-004 Parameter T_RFC_CYC, default 9, is the number of NOP cycles after each AUTO REFRESH.
REQ-005 Parameter T_MRD_CYC, default 2, is the number of NOP cycles after LOAD MODE.
REQ-006 Parameter REFRESH_COUNT, default 8, is the number of AUTO REFRESH commands issued (1..15).
REQ-007 Parameter MODE_REG, default 13'h0030, is the mode-register value (CAS 3, burst length 1, sequential).
REQ-008 i_clk  input  1  single clock, 133 MHz SDRAM clock from the MMCM.
REQ-009 i_rstn  input  1  asynchronous, active-low reset.
REQ-010 i_pll_locked  input  1  MMCM lock indicator, asynchronous to i_clk.
REQ-011 o_cke  output  1  SDRAM clock enable.
REQ-012 o_cmd  output  4  {cs_n, ras_n, cas_n, we_n}.
REQ-013 o_addr  output  13  SDRAM address bus.
REQ-014 o_ba  output  2  SDRAM bank address.
REQ-015 o_init_done  output  1  high when init is complete and the controller may take the bus.

Function
REQ-016 i_pll_locked SHALL pass through a 2-flop synchroniser; "locked" below means the synchronised value.
REQ-017 States SHALL be WAIT_LOCK, PWRUP_WAIT, PRECHARGE, WAIT_RP, REFRESH, WAIT_RFC, LOAD_MODE, WAIT_MRD, DONE.
REQ-018 WAIT_LOCK: o_cke=0, o_cmd=NOP (4'b0111); on locked=1, go to PWRUP_WAIT.
REQ-019 PWRUP_WAIT: o_cke=1, NOP for exactly CLK_FREQ_MHZ*PWRUP_US cycles (26600 at defaults), then PRECHARGE.
REQ-020 PRECHARGE: o_cmd=4'b0010 with o_addr[10]=1 for one cycle, then WAIT_RP.
REQ-021 WAIT_RP: NOP for exactly T_RP_CYC cycles, then REFRESH.
REQ-022 REFRESH: o_cmd=4'b0001 for one cycle, then WAIT_RFC.
REQ-023 WAIT_RFC: NOP for T_RFC_CYC cycles, then REFRESH if fewer than REFRESH_COUNT refreshes have been issued, else LOAD_MODE.
REQ-024 LOAD_MODE: o_cmd=4'b0000, o_addr=MODE_REG, o_ba=0 for one cycle, then WAIT_MRD.
REQ-025 WAIT_MRD: NOP for T_MRD_CYC cycles, then DONE.
REQ-026 DONE: o_init_done=1, o_cke=1, o_cmd=NOP; remains until lock loss or reset.
REQ-027 Lock loss (locked=0) in any state other than WAIT_LOCK SHALL, on the next edge, return to WAIT_LOCK with o_init_done=0, o_cke=0, and the counters cleared.
REQ-028 o_addr and o_ba SHALL be 0 whenever o_cmd is NOP or AUTO REFRESH.
REQ-029 All outputs SHALL be registered, with no combinational path from inputs.
REQ-030 The wait counter SHALL be 16 bits wide and the refresh counter 4 bits wide; neither SHALL wrap.

Reset
REQ-031 When i_rstn=0, the block SHALL asynchronously set state to WAIT_LOCK, the synchroniser to 0, counters to 0, o_cke=0, o_cmd=4'b0111, o_addr=0, o_ba=0 and o_init_done=0.
REQ-032 Reset asserted mid-sequence SHALL abort immediately; after release, the sequence SHALL restart from WAIT_LOCK.

Configuration
REQ-033 With macro SDRAM_PWRUP_FAST_SIM_EN defined, the PWRUP_WAIT duration SHALL be fixed at 16 cycles.
REQ-034 Without SDRAM_PWRUP_FAST_SIM_EN, the PWRUP_WAIT duration SHALL be CLK_FREQ_MHZ*PWRUP_US cycles.

Structure
REQ-035 The state enum, the SDRAM command encodings (NOP, PRECHARGE, REFRESH, LOAD_MODE) and the fast-sim wait constant SHALL live in shared package sdram_pkg, reused by the SDRAM controller.
REQ-036 The lock synchroniser SHALL be a separate sub-module, sync_2ff, for reuse on the 25 MHz domain.

Verification
REQ-037 FAST_SIM, defaults, reset released, lock rises at cycle 0 -> first PRECHARGE appears 2+16 cycles after lock is seen, and o_init_done rises 103 cycles after synchronised lock.
REQ-038 Full sequence -> exactly 1 PRECHARGE with A10=1, exactly 8 AUTO REFRESH commands spaced 10 cycles apart, and 1 LOAD_MODE with o_addr=13'h0030.
REQ-039 Lock dropped during the 4th WAIT_RFC -> WAIT_LOCK with o_cke=0 within 3 cycles; after relock, a full sequence with 8 refreshes repeats.
REQ-040 i_rstn pulsed low during PWRUP_WAIT -> outputs reach reset values asynchronously; o_init_done stays 0 until the sequence completes again.
REQ-041 Lock glitch shorter than 1 i_clk cycle while in WAIT_LOCK -> either no start or a clean start, with no partial command ever issued.
REQ-042 Non-FAST_SIM build, defaults -> PWRUP_WAIT lasts exactly 26600 cycles of NOP with o_cke=1.
